// File: rtl/nvm_chan_pkg.sv
// Shared types and helpers for the NVM channel model read-back path.
// Vth values are unsigned 16-bit, scaled by 2^11 per volt.
package nvm_chan_pkg;

  typedef logic [1:0] level_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int unsigned VTH_SCALE = 2048;
  localparam logic [15:0] RD_T1_DEF = 16'(1 * VTH_SCALE);
  localparam logic [15:0] RD_T2_DEF = 16'(3 * VTH_SCALE);
  localparam logic [15:0] RD_T3_DEF = 16'(5 * VTH_SCALE);

  // Adjacent levels differ in exactly one bit.
  function automatic logic [1:0] gray_of(level_t lvl);
    logic [1:0] g;
    case (lvl)
      2'd0:    g = 2'b11;
      2'd1:    g = 2'b10;
      2'd2:    g = 2'b00;
      default: g = 2'b01;
    endcase
    return g;
  endfunction

  function automatic logic [1:0] popcount2(logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/vth_level_detector_if.sv
// Cell stream in, per-cell result and frame error totals out.
interface vth_level_detector_if #(
  parameter int ERR_W = 16
) ();
  import nvm_chan_pkg::*;

  logic             start;
  logic             in_valid;
  logic [31:0]      in_data;
  level_t           in_level;
  logic             out_valid;
  level_t           out_level;
  logic [1:0]       out_bit_err;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] bit_err_count;
  logic [ERR_W-1:0] sym_err_count;

  modport master (
    output start, in_valid, in_data, in_level,
    input  out_valid, out_level, out_bit_err, busy, done, bit_err_count, sym_err_count
  );

  modport slave (
    input  start, in_valid, in_data, in_level,
    output out_valid, out_level, out_bit_err, busy, done, bit_err_count, sym_err_count
  );

endinterface

// File: rtl/vth_quantizer.sv
// Three-threshold hard-decision slicer; equality resolves to the upper level.
module vth_quantizer
  import nvm_chan_pkg::*;
#(
  parameter logic [15:0] T1 = RD_T1_DEF,
  parameter logic [15:0] T2 = RD_T2_DEF,
  parameter logic [15:0] T3 = RD_T3_DEF
) (
  input  logic [15:0] vth_i,
  output level_t      level_o,
  output logic [1:0]  gray_o
);

  always_comb begin
    level_o = 2'd0;
    if (vth_i >= T3)      level_o = 2'd3;
    else if (vth_i >= T2) level_o = 2'd2;
    else if (vth_i >= T1) level_o = 2'd1;
    gray_o = gray_of(level_o);
  end

endmodule

// File: rtl/vth_level_detector.sv
// Frame-based MLC read-back: slice, Gray-compare, accumulate bit/symbol errors.
//   state | meaning
//   IDLE  | counters hold last frame, wait for start
//   RUN   | accept cells until FRAME_LEN taken
//   DRAIN | 2 cycles for the last cells to reach the counters
//   DONE  | done pulse, totals final
module vth_level_detector
  import nvm_chan_pkg::*;
#(
  parameter logic [15:0] RD_T1     = RD_T1_DEF,
  parameter logic [15:0] RD_T2     = RD_T2_DEF,
  parameter logic [15:0] RD_T3     = RD_T3_DEF,
  parameter int          FRAME_LEN = 1024,
  parameter int          ERR_W     = 16
) (
  input logic            clk,
  input logic            reset,
  vth_level_detector_if.slave bus
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(FRAME_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_q;
  logic [CNT_W-1:0] cell_cnt_q;
  logic             drain_cnt_q;
  logic             busy_q, done_q;

  level_t           det_level;
  logic [1:0]       det_gray;
  logic             accept;

  logic             s1_valid_q;
  level_t           s1_level_q, s1_wr_level_q;
  logic [1:0]       s1_gray_q;

  logic             out_valid_q;
  level_t           out_level_q;
  logic [1:0]       out_bit_err_q;
  logic [ERR_W-1:0] bit_cnt_q, sym_cnt_q;

  logic [1:0]       bit_err_d;
  logic             sym_err_d;
  logic [ERR_W:0]   bit_sum_d;
  logic [ERR_W-1:0] bit_cnt_d, sym_cnt_d;
  logic             unused_erased;

  assign unused_erased = ^bus.in_data[15:0];
  assign accept = (state_q == RUN) && bus.in_valid;

  vth_quantizer #(.T1(RD_T1), .T2(RD_T2), .T3(RD_T3)) u_quant (
    .vth_i   (bus.in_data[31:16]),
    .level_o (det_level),
    .gray_o  (det_gray)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cell_cnt_q  <= '0;
      drain_cnt_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q    <= RUN;
          cell_cnt_q <= '0;
          busy_q     <= 1'b1;
        end
        RUN: if (accept) begin
          if (cell_cnt_q == LAST_CELL) begin
            state_q     <= DRAIN;
            drain_cnt_q <= 1'b0;
          end else begin
            cell_cnt_q <= cell_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_level_q    <= '0;
      s1_wr_level_q <= '0;
      s1_gray_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_level_q    <= det_level;
        s1_gray_q     <= det_gray;
        s1_wr_level_q <= bus.in_level;
      end
    end
  end

  // Saturating accumulation; the overflow bit of the sum flags a clamp.
  always_comb begin
    bit_err_d = popcount2(s1_gray_q ^ gray_of(s1_wr_level_q));
    sym_err_d = (s1_level_q != s1_wr_level_q);
    bit_sum_d = {1'b0, bit_cnt_q} + {{(ERR_W-1){1'b0}}, bit_err_d};
    bit_cnt_d = bit_sum_d[ERR_W] ? ERR_MAX : bit_sum_d[ERR_W-1:0];
    sym_cnt_d = (sym_cnt_q == ERR_MAX) ? sym_cnt_q : sym_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_level_q   <= '0;
      out_bit_err_q <= '0;
      bit_cnt_q     <= '0;
      sym_cnt_q     <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_level_q   <= s1_level_q;
        out_bit_err_q <= bit_err_d;
      end
      if (state_q == IDLE && bus.start) begin
        bit_cnt_q <= '0;
        sym_cnt_q <= '0;
      end else if (s1_valid_q) begin
        bit_cnt_q <= bit_cnt_d;
        if (sym_err_d) sym_cnt_q <= sym_cnt_d;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_level     = out_level_q;
  assign bus.out_bit_err   = out_bit_err_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.bit_err_count = bit_cnt_q;
  assign bus.sym_err_count = sym_cnt_q;

endmodule

// File: tb/tb_vth_level_detector.sv
// Scoreboard bench: three detector instances (frame 4, frame 3, 2-bit counters).
module tb_vth_level_detector;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_s[3], in_valid_s[3];
  logic [31:0] data_s[3];
  logic [1:0]  lvl_s[3];
  logic        ov[3], busy_o[3], done_o[3];
  logic [1:0]  ol[3], obe[3];
  logic [15:0] bec[3], sec[3];

  vth_level_detector_if #(.ERR_W(16)) if_a ();
  vth_level_detector_if #(.ERR_W(16)) if_b ();
  vth_level_detector_if #(.ERR_W(2))  if_c ();

  vth_level_detector #(.FRAME_LEN(4), .ERR_W(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  vth_level_detector #(.FRAME_LEN(3), .ERR_W(16)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  vth_level_detector #(.FRAME_LEN(4), .ERR_W(2))  dut_c (.clk(clk), .reset(reset), .bus(if_c));

  assign if_a.start = start_s[0]; assign if_a.in_valid = in_valid_s[0];
  assign if_a.in_data = data_s[0]; assign if_a.in_level = lvl_s[0];
  assign if_b.start = start_s[1]; assign if_b.in_valid = in_valid_s[1];
  assign if_b.in_data = data_s[1]; assign if_b.in_level = lvl_s[1];
  assign if_c.start = start_s[2]; assign if_c.in_valid = in_valid_s[2];
  assign if_c.in_data = data_s[2]; assign if_c.in_level = lvl_s[2];

  assign ov[0] = if_a.out_valid; assign ol[0] = if_a.out_level; assign obe[0] = if_a.out_bit_err;
  assign busy_o[0] = if_a.busy; assign done_o[0] = if_a.done;
  assign bec[0] = if_a.bit_err_count; assign sec[0] = if_a.sym_err_count;
  assign ov[1] = if_b.out_valid; assign ol[1] = if_b.out_level; assign obe[1] = if_b.out_bit_err;
  assign busy_o[1] = if_b.busy; assign done_o[1] = if_b.done;
  assign bec[1] = if_b.bit_err_count; assign sec[1] = if_b.sym_err_count;
  assign ov[2] = if_c.out_valid; assign ol[2] = if_c.out_level; assign obe[2] = if_c.out_bit_err;
  assign busy_o[2] = if_c.busy; assign done_o[2] = if_c.done;
  assign bec[2] = {14'b0, if_c.bit_err_count}; assign sec[2] = {14'b0, if_c.sym_err_count};

  typedef struct {
    int         dut;
    logic [1:0] lvl;
    logic [1:0] be;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d] === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_unexpected_out_valid: dut %0d level %0d with no expected cell at %0t",
                     d, ol[d], $time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_dut", 32'(d), 32'(e.dut));
            chk("sb_level", 32'(ol[d]), 32'(e.lvl));
            chk("sb_bit_err", 32'(obe[d]), 32'(e.be));
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int d);
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [15:0] vth, input logic [1:0] wl,
                      input logic [1:0] el, input logic [1:0] eb, input bit push);
    data_s[d]     = {vth, 16'h5A5A};
    lvl_s[d]      = wl;
    in_valid_s[d] = 1'b1;
    if (push) exp_q.push_back('{d, el, eb});
    tick();
    in_valid_s[d] = 1'b0;
  endtask

  // Called right after the last cell; done must arrive on the 3rd negedge.
  task automatic wait_done(input int d, input int eb, input int es);
    int n;
    n = 0;
    for (int i = 1; i <= 12 && n == 0; i++) begin
      @(negedge clk);
      if (done_o[d] === 1'b1) n = i;
    end
    chk("done_latency", 32'(n), 32'd3);
    chk("bit_err_count", 32'(bec[d]), 32'(eb));
    chk("sym_err_count", 32'(sec[d]), 32'(es));
    @(negedge clk);
    chk("done_one_cycle", 32'(done_o[d]), 32'd0);
    chk("busy_after_done", 32'(busy_o[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0; in_valid_s[d] = 1'b0; data_s[d] = '0; lvl_s[d] = '0;
    end
    reset = 1'b1;
    fork
      run_monitor();
    join_none
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_busy", 32'(busy_o[0]), 32'd0);
    chk("rst_done", 32'(done_o[0]), 32'd0);
    chk("rst_bit_cnt", 32'(bec[0]), 32'd0);
    chk("rst_sym_cnt", 32'(sec[0]), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Nominal frame, one cell per level
    start_frame(0);
    chk("busy_run", 32'(busy_o[0]), 32'd1);
    send(0, 16'h0400, 2'd0, 2'd0, 2'd0, 1);
    send(0, 16'h1000, 2'd1, 2'd1, 2'd0, 1);
    send(0, 16'h2000, 2'd2, 2'd2, 2'd0, 1);
    send(0, 16'h3000, 2'd3, 2'd3, 2'd0, 1);
    wait_done(0, 0, 0);

    // Threshold boundaries, equality goes up
    start_frame(0);
    send(0, 16'h07FF, 2'd0, 2'd0, 2'd0, 1);
    send(0, 16'h0800, 2'd1, 2'd1, 2'd0, 1);
    send(0, 16'h17FF, 2'd1, 2'd1, 2'd0, 1);
    send(0, 16'h1800, 2'd2, 2'd2, 2'd0, 1);
    wait_done(0, 0, 0);
    start_frame(0);
    send(0, 16'h2800, 2'd3, 2'd3, 2'd0, 1);
    send(0, 16'hFFFF, 2'd3, 2'd3, 2'd0, 1);
    send(0, 16'h27FF, 2'd2, 2'd2, 2'd0, 1);
    send(0, 16'h0000, 2'd0, 2'd0, 2'd0, 1);
    wait_done(0, 0, 0);

    // Error accumulation, frame of 3
    start_frame(1);
    send(1, 16'h1000, 2'd0, 2'd1, 2'd1, 1);
    send(1, 16'h2000, 2'd0, 2'd2, 2'd2, 1);
    send(1, 16'h0000, 2'd3, 2'd0, 2'd1, 1);
    wait_done(1, 4, 3);

    // Ignored in_valid in IDLE; start+in_valid together does not take the cell
    send(1, 16'h3000, 2'd0, 2'd0, 2'd0, 0);
    tick();
    chk("idle_hold_bit", 32'(bec[1]), 32'd4);
    chk("idle_hold_sym", 32'(sec[1]), 32'd3);
    start_s[1] = 1'b1;
    send(1, 16'h3000, 2'd0, 2'd0, 2'd0, 0);
    start_s[1] = 1'b0;
    send(1, 16'h0000, 2'd1, 2'd0, 2'd1, 1);
    start_frame(1);
    send(1, 16'h1800, 2'd2, 2'd2, 2'd0, 1);
    send(1, 16'h2800, 2'd2, 2'd3, 2'd1, 1);
    send(1, 16'h3000, 2'd0, 2'd0, 2'd0, 0);
    tick();
    start_s[1] = 1'b1; in_valid_s[1] = 1'b1; data_s[1] = 32'h3000_0000; lvl_s[1] = 2'd0;
    @(negedge clk);
    chk("done_after_pulses", 32'(done_o[1]), 32'd1);
    chk("pulse_bit_cnt", 32'(bec[1]), 32'd2);
    chk("pulse_sym_cnt", 32'(sec[1]), 32'd2);
    tick();
    start_s[1] = 1'b0; in_valid_s[1] = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy_o[1]), 32'd0);
    chk("done_cleared", 32'(done_o[1]), 32'd0);
    chk("pulse_bit_hold", 32'(bec[1]), 32'd2);

    // Saturation with 2-bit counters
    start_frame(2);
    send(2, 16'h2000, 2'd0, 2'd2, 2'd2, 1);
    send(2, 16'h2000, 2'd0, 2'd2, 2'd2, 1);
    send(2, 16'h0400, 2'd2, 2'd0, 2'd2, 1);
    send(2, 16'h0400, 2'd2, 2'd0, 2'd2, 1);
    wait_done(2, 3, 3);

    // Asynchronous reset mid-frame
    start_frame(0);
    send(0, 16'h3000, 2'd0, 2'd3, 2'd1, 0);
    send(0, 16'h3000, 2'd0, 2'd3, 2'd1, 0);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(ov[0]), 32'd0);
    chk("arst_busy", 32'(busy_o[0]), 32'd0);
    chk("arst_bit_cnt", 32'(bec[0]), 32'd0);
    chk("arst_sym_cnt", 32'(sec[0]), 32'd0);
    chk("arst_out_level", 32'(ol[0]), 32'd0);
    chk("arst_out_bit_err", 32'(obe[0]), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 32'(busy_o[0]), 32'd0);
    tick();
    start_frame(0);
    send(0, 16'h0000, 2'd0, 2'd0, 2'd0, 1);
    send(0, 16'h1234, 2'd1, 2'd1, 2'd0, 1);
    send(0, 16'h2000, 2'd1, 2'd2, 2'd1, 1);
    send(0, 16'h2800, 2'd3, 2'd3, 2'd0, 1);
    wait_done(0, 1, 1);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
